// File: rtl/keccak_sponge_ctrl.sv
// rtl/keccak_sponge_ctrl.sv - streaming sponge controller (absorb, pad, squeeze) for the sha3 core
module keccak_sponge_ctrl #(
    parameter int OUTLEN_W = 16,
    parameter int CORE_AW  = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [OUTLEN_W-1:0] out_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_data,
    input  logic                in_last,
    input  logic [2:0]          in_bytes,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_data,
    output logic                out_last,
    output logic                busy,
    output logic                core_w,
    output logic [CORE_AW-1:0]  core_addr,
    output logic [31:0]         core_din,
    output logic                core_init,
    output logic                core_next,
    input  logic [31:0]         core_dout,
    input  logic                core_ready
);

    typedef enum logic [3:0] {
        S_IDLE, S_ABSORB, S_PAD, S_PERM, S_PERM_HOLD, S_PERM_WAIT,
        S_SQ_ADDR, S_SQ_WAIT, S_SQ_CAP, S_SQ_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [OUTLEN_W-1:0] remain_q, remain_d;
    logic [5:0]          idx_q, idx_d;
    logic                first_q, first_d;
    logic                pad_q, pad_d;
    logic                pad_first_q, pad_first_d;
    logic                dpend_q, dpend_d;
    logic                done_q, done_d;
    logic [31:0]         last_data_q, last_data_d;
    logic                last_full_q, last_full_d;
    logic [1:0]          last_bytes_q, last_bytes_d;
    logic                core_w_q, core_w_d;
    logic [CORE_AW-1:0]  core_addr_q, core_addr_d;
    logic [31:0]         core_din_q, core_din_d;
    logic                core_init_q, core_init_d;
    logic                core_next_q, core_next_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;
    logic                out_last_q, out_last_d;

    logic [5:0]          rw_m1;
    logic [7:0]          dom;
    logic                at_end;
    logic                d_defer;
    logic [31:0]         byte_mask;
    logic [31:0]         pad_word;

    always_comb begin
        case (mode_q)
            2'b00:   rw_m1 = 6'd41;
            2'b01:   rw_m1 = 6'd33;
            2'b10:   rw_m1 = 6'd33;
            default: rw_m1 = 6'd17;
        endcase
    end

    assign dom       = mode_q[1] ? 8'h06 : 8'h1F;
    assign at_end    = (idx_q == rw_m1);
    // A full final word pushes the domain byte into the following word.
    assign d_defer   = pad_first_q && last_full_q;
    assign byte_mask = ~(32'hFFFF_FFFF << {last_bytes_q, 3'b000});

    always_comb begin
        pad_word = 32'h0;
        if (pad_first_q) begin
            if (last_full_q) begin
                pad_word = last_data_q;
            end else begin
                pad_word = (last_data_q & byte_mask) | ({24'h0, dom} << {last_bytes_q, 3'b000});
            end
        end else if (dpend_q) begin
            pad_word = {24'h0, dom};
        end
        if (at_end && !d_defer) begin
            pad_word = pad_word | 32'h8000_0000;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        remain_d     = remain_q;
        idx_d        = idx_q;
        first_d      = first_q;
        pad_d        = pad_q;
        pad_first_d  = pad_first_q;
        dpend_d      = dpend_q;
        done_d       = done_q;
        last_data_d  = last_data_q;
        last_full_d  = last_full_q;
        last_bytes_d = last_bytes_q;
        core_w_d     = 1'b0;
        core_addr_d  = core_addr_q;
        core_din_d   = core_din_q;
        core_init_d  = 1'b0;
        core_next_d  = 1'b0;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = mode;
                    idx_d   = 6'd0;
                    first_d = 1'b1;
                    pad_d   = 1'b0;
                    dpend_d = 1'b0;
                    done_d  = 1'b0;
                    case (mode)
                        2'b10:   remain_d = OUTLEN_W'(8);
                        2'b11:   remain_d = OUTLEN_W'(16);
                        default: remain_d = (out_len == '0) ? OUTLEN_W'(1) : out_len;
                    endcase
                    state_d = S_ABSORB;
                end
            end
            S_ABSORB: begin
                if (in_valid && core_ready) begin
                    core_w_d    = 1'b1;
                    core_addr_d = CORE_AW'(idx_q);
                    core_din_d  = in_data;
                    if (in_last) begin
                        last_data_d  = in_data;
                        last_full_d  = in_bytes[2];
                        last_bytes_d = in_bytes[1:0];
                        pad_d        = 1'b1;
                        pad_first_d  = 1'b1;
                        state_d      = S_PAD;
                    end else if (at_end) begin
                        state_d = S_PERM;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_PAD: begin
                // Rewrites the final message word in place, then fills the block.
                core_w_d    = 1'b1;
                core_addr_d = CORE_AW'(idx_q);
                core_din_d  = pad_word;
                pad_first_d = 1'b0;
                dpend_d     = d_defer;
                if (at_end) begin
                    done_d  = !d_defer;
                    state_d = S_PERM;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            S_PERM: begin
                core_init_d = first_q;
                core_next_d = !first_q;
                first_d     = 1'b0;
                state_d     = S_PERM_HOLD;
            end
            S_PERM_HOLD: begin
                state_d = S_PERM_WAIT;
            end
            S_PERM_WAIT: begin
                if (core_ready) begin
                    idx_d = 6'd0;
                    if (done_q) begin
                        state_d = S_SQ_ADDR;
                    end else if (pad_q) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_ABSORB;
                    end
                end
            end
            S_SQ_ADDR: begin
                core_addr_d = CORE_AW'(idx_q);
                state_d     = S_SQ_WAIT;
            end
            S_SQ_WAIT: begin
                state_d = S_SQ_CAP;
            end
            S_SQ_CAP: begin
                out_data_d  = core_dout;
                out_valid_d = 1'b1;
                out_last_d  = (remain_q == OUTLEN_W'(1));
                state_d     = S_SQ_OUT;
            end
            S_SQ_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (remain_q == OUTLEN_W'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        remain_d = remain_q - OUTLEN_W'(1);
                        if (at_end) begin
                            state_d = S_PERM;
                        end else begin
                            idx_d   = idx_q + 6'd1;
                            state_d = S_SQ_ADDR;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= 2'b00;
            remain_q     <= '0;
            idx_q        <= 6'd0;
            first_q      <= 1'b0;
            pad_q        <= 1'b0;
            pad_first_q  <= 1'b0;
            dpend_q      <= 1'b0;
            done_q       <= 1'b0;
            last_data_q  <= 32'h0;
            last_full_q  <= 1'b0;
            last_bytes_q <= 2'b00;
            core_w_q     <= 1'b0;
            core_addr_q  <= '0;
            core_din_q   <= 32'h0;
            core_init_q  <= 1'b0;
            core_next_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'h0;
            out_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            remain_q     <= remain_d;
            idx_q        <= idx_d;
            first_q      <= first_d;
            pad_q        <= pad_d;
            pad_first_q  <= pad_first_d;
            dpend_q      <= dpend_d;
            done_q       <= done_d;
            last_data_q  <= last_data_d;
            last_full_q  <= last_full_d;
            last_bytes_q <= last_bytes_d;
            core_w_q     <= core_w_d;
            core_addr_q  <= core_addr_d;
            core_din_q   <= core_din_d;
            core_init_q  <= core_init_d;
            core_next_q  <= core_next_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    assign in_ready  = (state_q == S_ABSORB) && core_ready;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign core_w    = core_w_q;
    assign core_addr = core_addr_q;
    assign core_din  = core_din_q;
    assign core_init = core_init_q;
    assign core_next = core_next_q;

endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
Streaming sponge controller that drives the team's `sha3` permutation core through its word-addressed buffer interface.
- Absorbs a byte-granular message over a valid/ready stream and applies mode-correct multi-rate padding.
- Squeezes an arbitrary number of 32-bit output words, issuing further permutations when the output exceeds one rate block.
- Supports SHAKE128, SHAKE256, SHA3-256 and SHA3-512, and replaces the fixed address-fetch absorber used by earlier samplers.

Parameters:
- OUTLEN_W, 16: width of the requested squeeze length in 32-bit words.
- CORE_AW, 7: core buffer word-address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle pulse; latches mode/out_len; ignored while busy.
- mode  in  2  00 SHAKE128, 01 SHAKE256, 10 SHA3-256, 11 SHA3-512.
- out_len  in  OUTLEN_W  squeeze length in words (SHAKE only; 0 treated as 1).
- in_valid  in  1  message word valid.
- in_ready  out  1  controller accepts a word.
- in_data  in  32  message word, little-endian (byte0 = bits[7:0]).
- in_last  in  1  final message word.
- in_bytes  in  3  valid bytes in the final word, 0..4; ignored unless in_last.
- out_valid  out  1  squeeze word valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  32  squeezed word.
- out_last  out  1  marks the final squeeze word.
- busy  out  1  high from the accepted start until the last output handshake.
- core_w  out  1  core buffer write strobe.
- core_addr  out  CORE_AW  core word address.
- core_din  out  32  core write data.
- core_init  out  1  first-block permutation pulse.
- core_next  out  1  subsequent-block permutation pulse.
- core_dout  in  32  core state word; valid 1 cycle after core_addr.
- core_ready  in  1  core idle.

Behaviour:
- Rate RW (words) and domain byte D per mode:
  - SHAKE128: 42, 0x1F
  - SHAKE256: 34, 0x1F
  - SHA3-256: 34, 0x06
  - SHA3-512: 18, 0x06
- Total squeeze words: SHA3-256 = 8, SHA3-512 = 16, SHAKE = out_len.
- All core_* signals are registered.
- Reset values: all outputs 0; FSM in IDLE.
- FSM states:
  - IDLE → ABSORB on start.
  - ABSORB: in_ready = core_ready.
    - Each handshake writes in_data to word index widx (core_w = 1, core_addr = widx).
    - widx == RW-1 without in_last → PERMUTE.
    - in_last → PAD.
  - PAD: one write per cycle until widx == RW-1, then → PERMUTE.
    - First pad write is the last word, masked to in_bytes with D in byte in_bytes.
    - If in_bytes == 4, that word is written unchanged and D goes in byte 0 of the next word.
    - Remaining words are 0.
    - Word RW-1 has bit 31 ORed in (0x80 into the final rate byte). If D lands in that same byte, the byte is D|0x80.
    - If the message ended exactly on the block's final word with in_bytes == 4, a full extra block is absorbed: D at word 0 byte 0, 0x80000000 at word RW-1.
  - PERMUTE:
    - Pulse core_init for 1 cycle on the first permutation of the operation, core_next thereafter.
    - Ignore core_ready for 1 cycle after the pulse, then wait for core_ready = 1.
    - Return to ABSORB (message continues, widx = 0) or → SQUEEZE (padding done).
  - SQUEEZE:
    - Drive core_addr = ridx; the following cycle present core_dout as out_data with out_valid = 1.
    - Hold out_data/out_valid stable until out_ready.
    - Throughput is at most 1 word per 2 cycles.
    - After a handshake on ridx == RW-1 with words remaining → PERMUTE (core_next), ridx = 0.
    - Final word: out_last = 1; after its handshake → IDLE, busy = 0.
- Word counters are OUTLEN_W bits wide; out_len up to 2^OUTLEN_W-1 must not wrap.
- in_valid outside ABSORB is ignored (in_ready = 0).
- start during busy is ignored.
- Asynchronous reset mid-operation: immediate return to IDLE, all outputs 0; core state undefined until the next start.

Test Plan:
- SHAKE128, in_last with in_bytes = 0, out_len = 8 → 1 permutation (core_init); out_data words 0x a42b9c7f, 0x7d828fe8, ...; out_last on word 8.
- SHA3-256, single word 0x00636261 with in_last, in_bytes = 3 → core_din word0 = 0x06636261, word33 = 0x80000000; output word0 = 0xa75d983a, 8 words total.
- SHAKE256, empty message, out_len = 4 → output word0 = 0x2bddb946.
- SHAKE256, 136-byte message (34 full words, in_last on word 34, in_bytes = 4) → 2 permutations (init then next); pad block is word0 = 0x0000001F, word33 = 0x80000000.
- SHAKE128, out_len = 50 → exactly one core_next issued after the 42nd output handshake; 50 outputs, out_last only on the 50th.
- Random out_ready backpressure plus a start pulse mid-squeeze → out_data held stable while stalled, start ignored; rst_n pulse mid-ABSORB → all outputs 0, FSM returns to IDLE, next start operates normally.
